// File: rtl/lut_interp.sv
// Three-stage piecewise-linear activation interpolator.
// Segment lookup, LUT capture, then interpolate and saturate.
module lut_interp (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_x,
    output logic [3:0] lut_address,
    input  logic [7:0] lut_base,
    input  logic [7:0] lut_next,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_y
);

    logic        advance;

    logic        s0_valid_q, s0_valid_d;
    logic [3:0]  s0_seg_q,   s0_seg_d;
    logic [3:0]  s0_frac_q,  s0_frac_d;

    logic        s1_valid_q, s1_valid_d;
    logic [7:0]  s1_base_q,  s1_base_d;
    logic [7:0]  s1_next_q,  s1_next_d;
    logic [3:0]  s1_frac_q,  s1_frac_d;

    logic        s2_valid_q, s2_valid_d;
    logic [7:0]  s2_y_q,     s2_y_d;

    logic signed [8:0]  diff;
    logic signed [13:0] base_ext;
    logic signed [13:0] diff_ext;
    logic signed [13:0] frac_ext;
    logic signed [13:0] acc;
    logic signed [13:0] shifted;
    logic [7:0]         y_sat;

    // Handshake: the whole pipe moves only when S2 can be emptied.
    always_comb begin
        advance  = !s2_valid_q || out_ready;
        in_ready = advance;
    end

    // Interpolation: base*16 + (next-base)*frac, floor >>4, clip.
    always_comb begin
        diff = $signed({s1_next_q[7], s1_next_q})
             - $signed({s1_base_q[7], s1_base_q});
        base_ext = $signed({{6{s1_base_q[7]}}, s1_base_q});
        diff_ext = $signed({{5{diff[8]}}, diff});
        frac_ext = $signed({10'b0, s1_frac_q});
        acc      = (base_ext <<< 4) + diff_ext * frac_ext;
        shifted  = acc >>> 4;
        if (shifted > 14'sd127) begin
            y_sat = 8'h7F;
        end else if (shifted < -14'sd128) begin
            y_sat = 8'h80;
        end else begin
            y_sat = shifted[7:0];
        end
    end

    // Next-state for all stages; everything holds on a stall.
    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_seg_d   = s0_seg_q;
        s0_frac_d  = s0_frac_q;
        s1_valid_d = s1_valid_q;
        s1_base_d  = s1_base_q;
        s1_next_d  = s1_next_q;
        s1_frac_d  = s1_frac_q;
        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        if (advance) begin
            s0_valid_d = in_valid;
            if (in_valid) begin
                s0_seg_d  = in_x[7:4];
                s0_frac_d = in_x[3:0];
            end
            s1_valid_d = s0_valid_q;
            s1_base_d  = lut_base;
            s1_next_d  = lut_next;
            s1_frac_d  = s0_frac_q;
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_y_d = y_sat;
            end
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_seg_q   <= 4'd0;
            s0_frac_q  <= 4'd0;
            s1_valid_q <= 1'b0;
            s1_base_q  <= 8'd0;
            s1_next_q  <= 8'd0;
            s1_frac_q  <= 4'd0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= 8'd0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_seg_q   <= s0_seg_d;
            s0_frac_q  <= s0_frac_d;
            s1_valid_q <= s1_valid_d;
            s1_base_q  <= s1_base_d;
            s1_next_q  <= s1_next_d;
            s1_frac_q  <= s1_frac_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
        end
    end

    assign lut_address = s0_seg_q;
    assign out_valid   = s2_valid_q;
    assign out_y       = s2_y_q;

endmodule

// File: tb/tb_lut_interp.sv
// Directed bench for lut_interp with a linear external LUT
// and a switchable custom base/next pair.
module tb_lut_interp;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [3:0] lut_address;
    logic [7:0] lut_base;
    logic [7:0] lut_next;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;

    logic       custom;
    logic [7:0] cust_base;
    logic [7:0] cust_next;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] res_q[$];
    int         cyc_q[$];

    logic [7:0] b2b_exp [16] = '{
        8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h70,
        8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF
    };

    lut_interp dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .lut_address(lut_address),
        .lut_base(lut_base),
        .lut_next(lut_next),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y(out_y)
    );

    always #5 clk = ~clk;

    // Linear LUT: entry k = 16*k mod 256, seg 15 wraps, seg 7 clamps.
    always_comb begin
        lut_base = {lut_address, 4'h0};
        if (lut_address == 4'd7) begin
            lut_next = 8'h70;
        end else begin
            lut_next = {lut_address + 4'd1, 4'h0};
        end
        if (custom) begin
            lut_base = cust_base;
            lut_next = cust_next;
        end
    end

    // Output monitor: records each accepted result and its cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst && out_valid && out_ready) begin
            res_q.push_back(out_y);
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag,
                           input logic [7:0] x,
                           input logic [7:0] exp);
        in_x = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check({tag, "_vld"}, 16'(out_valid), 16'd1);
        check({tag, "_y"}, 16'(out_y), 16'(exp));
        tick();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_x = 8'h00;
        out_ready = 1'b1;
        custom = 1'b0;
        cust_base = 8'h00;
        cust_next = 8'h00;
        #1;
        check("rst_vld", 16'(out_valid), 16'd0);
        check("rst_y", 16'(out_y), 16'd0);
        check("rst_addr", 16'(lut_address), 16'd0);
        check("rst_rdy", 16'(in_ready), 16'd1);
        tick();
        tick();
        rst = 1'b0;
        check("post_rst_rdy", 16'(in_ready), 16'd1);
        tick();

        // Single sample with latency checks.
        in_x = 8'h25;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_addr", 16'(lut_address), 16'd2);
        check("single_vld0", 16'(out_valid), 16'd0);
        tick();
        check("single_vld1", 16'(out_valid), 16'd0);
        tick();
        check("single_vld2", 16'(out_valid), 16'd1);
        check("single_y", 16'(out_y), 16'h25);
        tick();
        check("single_gone", 16'(out_valid), 16'd0);

        run_one("wrap", 8'hF8, 8'hF8);
        run_one("clamp", 8'h75, 8'h70);
        run_one("neg", 8'h80, 8'h80);

        // Back-to-back stream.
        res_q.delete();
        cyc_q.delete();
        for (int i = 0; i < 16; i++) begin
            in_x = 8'(i * 17);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("b2b_cnt", 16'(res_q.size()), 16'd16);
        if (res_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("b2b_%0d", i), 16'(res_q[i]),
                      16'(b2b_exp[i]));
            end
            check("b2b_span", 16'(cyc_q[15] - cyc_q[0]), 16'd15);
        end

        // Stall with three samples in flight.
        res_q.delete();
        cyc_q.delete();
        out_ready = 1'b0;
        in_x = 8'h25; in_valid = 1'b1; tick();
        in_x = 8'hF8; tick();
        in_x = 8'h80; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_y%0d", i), 16'(out_y), 16'h25);
            check($sformatf("stall_rdy%0d", i), 16'(in_ready), 16'd0);
            tick();
        end
        check("stall_vld", 16'(out_valid), 16'd1);
        check("stall_addr", 16'(lut_address), 16'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("stall_cnt", 16'(res_q.size()), 16'd3);
        if (res_q.size() == 3) begin
            check("stall_r0", 16'(res_q[0]), 16'h25);
            check("stall_r1", 16'(res_q[1]), 16'hF8);
            check("stall_r2", 16'(res_q[2]), 16'h80);
        end

        // Custom LUT endpoints.
        custom = 1'b1;
        cust_base = 8'h7F;
        cust_next = 8'h80;
        run_one("sat_dn", 8'h0F, 8'h8F);
        cust_next = 8'h7F;
        run_one("sat_flat", 8'h3F, 8'h7F);
        cust_base = 8'h80;
        run_one("sat_up", 8'h5F, 8'h6F);
        custom = 1'b0;

        // Reset with two samples in flight.
        res_q.delete();
        cyc_q.delete();
        out_ready = 1'b0;
        in_x = 8'h25; in_valid = 1'b1; tick();
        in_x = 8'h11; tick();
        in_valid = 1'b0;
        tick();
        check("mid_pre_vld", 16'(out_valid), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_vld", 16'(out_valid), 16'd0);
        check("mid_y", 16'(out_y), 16'd0);
        check("mid_addr", 16'(lut_address), 16'd0);
        check("mid_rdy", 16'(in_ready), 16'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("mid_none", 16'(res_q.size()), 16'd0);
        run_one("mid_after", 8'h25, 8'h25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
